// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd request master: FSM state encoding and
// default sizing constants.
// Exports: state_t (IDLE/ISSUE/WAIT/RESP), GCD_W, GCDM_TIMEOUT_DEFAULT.
package gcd_pkg;

  localparam int GCD_W                = 8;
  localparam int GCDM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/gcd_req_master.sv
// gcd_req_master: initiator for the gcd core start/done handshake. Accepts an
// operand pair on req_*, pulses gcd_start, waits for a rising edge of gcd_done
// and presents y/error on rsp_* until the consumer takes it. One request in flight.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_a/req_b upstream;
// rsp_valid/rsp_ready/rsp_y/rsp_err/rsp_timeout/rsp_cnt downstream; busy status;
// gcd_start/gcd_a/gcd_b/gcd_y/gcd_done/gcd_error towards the core.
// Build option: define GCDM_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles.
module gcd_req_master
  import gcd_pkg::*;
#(
  parameter int W           = GCD_W,
  parameter int TIMEOUT_CYC = GCDM_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic         rsp_err,
  output logic         rsp_timeout,
  output logic [7:0]   rsp_cnt,
  output logic         busy,
  output logic         gcd_start,
  output logic [W-1:0] gcd_a,
  output logic [W-1:0] gcd_b,
  input  logic [W-1:0] gcd_y,
  input  logic         gcd_done,
  input  logic         gcd_error
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("gcd_req_master: TIMEOUT_CYC must be in 1..65535");
  end

  state_t state;
  logic   done_q;
  logic   done_rise;

  // Only a fresh 0->1 transition counts as completion, so a done level left
  // over from the previous operation cannot end the current one.
  assign done_rise = gcd_done & ~done_q;

`ifdef GCDM_TIMEOUT_EN
  // Counter value on the WAIT cycle whose edge reaches TIMEOUT_CYC.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;
  logic        rsp_timeout_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_err   <= 1'b0;
      rsp_cnt   <= '0;
      busy      <= 1'b0;
      gcd_start <= 1'b0;
      gcd_a     <= '0;
      gcd_b     <= '0;
      done_q    <= 1'b0;
`ifdef GCDM_TIMEOUT_EN
      tmo_cnt       <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= gcd_done;
      case (state)
        IDLE: begin
          if (req_valid) begin
            gcd_a     <= req_a;
            gcd_b     <= req_b;
            gcd_start <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          gcd_start <= 1'b0;
`ifdef GCDM_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          state     <= WAIT;
        end
        WAIT: begin
          // Done takes priority over a simultaneous terminal count.
          if (done_rise) begin
            rsp_y     <= gcd_y;
            rsp_err   <= gcd_error;
`ifdef GCDM_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef GCDM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rsp_y         <= '0;
            rsp_err       <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid     <= 1'b1;
            tmo_cnt       <= tmo_cnt + 16'd1;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_cnt   <= rsp_cnt + 8'd1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_req_master.sv
// Self-checking bench for gcd_req_master with a behavioural gcd core whose
// done rises 6 cycles after start; a manual override drives done/y directly
// for the done-level and timeout corner cases.
module tb_gcd_req_master;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_err, rsp_timeout;
  logic [7:0]   rsp_cnt;
  logic         busy;
  logic         gcd_start;
  logic [W-1:0] gcd_a, gcd_b, gcd_y;
  logic         gcd_done, gcd_error;

  always #5 clk = ~clk;

  gcd_req_master #(.W(W), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_cnt(rsp_cnt),
    .busy(busy), .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_y(gcd_y), .gcd_done(gcd_done), .gcd_error(gcd_error)
  );

  // ---------------- behavioural core ----------------
  logic         auto_done = 1'b0;
  logic         auto_err  = 1'b0;
  logic [W-1:0] auto_y    = '0;
  int           mcnt      = 0;
  logic [W-1:0] ma, mb;
  logic         man_en = 1'b0, man_done = 1'b0, man_err = 1'b0;
  logic [W-1:0] man_y = '0;

  assign gcd_done  = man_en ? man_done : auto_done;
  assign gcd_y     = man_en ? man_y    : auto_y;
  assign gcd_error = man_en ? man_err  : auto_err;

  function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  always @(negedge clk) begin
    if (gcd_start === 1'b1) begin
      auto_done = 1'b0; mcnt = 6; ma = gcd_a; mb = gcd_b;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        auto_done = 1'b1;
        auto_err  = (ma == 0) || (mb == 0);
        auto_y    = auto_err ? '0 : euclid(ma, mb);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [W-1:0] y; logic err; logic to; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; }     sab_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] y; logic err; } vec_t;

  exp_t exp_q[$];
  sab_t start_q[$];
  int   total = 0, bad = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++; bad++;
    $display("FAIL %s", name);
  endtask

  // Observes the values the coming posedge will use, then advances to the
  // next negedge. Callers set inputs between ticks.
  task automatic tick();
    exp_t e; sab_t s;
    if (gcd_start === 1'b1) begin
      check("start one cycle", 32'(prev_start), 0);
      if (start_q.size() == 0) fail("unexpected start");
      else begin
        s = start_q.pop_front();
        check("start gcd_a", 32'(gcd_a), 32'(s.a));
        check("start gcd_b", 32'(gcd_b), 32'(s.b));
      end
    end
    prev_start = gcd_start;
    if (busy === 1'b1) check("req_ready while busy", 32'(req_ready), 0);
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) fail("unexpected response");
      else begin
        e = exp_q.pop_front();
        check("rsp_y", 32'(rsp_y), 32'(e.y));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] y, input logic err, input logic to);
    int n = 0;
    req_a = a; req_b = b; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 300) begin tick(); n++; end
    if (n >= 300) begin fail("request accept timeout"); req_valid = 1'b0; return; end
    exp_q.push_back('{y: y, err: err, to: to});
    start_q.push_back('{a: a, b: b});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    if (n >= 300) fail("response drain timeout");
  endtask

  task automatic wait_rsp_valid(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) fail("rsp_valid wait timeout");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"},   32'(req_ready), 1);
    check({tag, " rsp_valid"},   32'(rsp_valid), 0);
    check({tag, " rsp_y"},       32'(rsp_y), 0);
    check({tag, " rsp_err"},     32'(rsp_err), 0);
    check({tag, " rsp_timeout"}, 32'(rsp_timeout), 0);
    check({tag, " rsp_cnt"},     32'(rsp_cnt), 0);
    check({tag, " busy"},        32'(busy), 0);
    check({tag, " gcd_start"},   32'(gcd_start), 0);
    check({tag, " gcd_a"},       32'(gcd_a), 0);
    check({tag, " gcd_b"},       32'(gcd_b), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n;
    vecs[0] = '{a: 8'd6,   b: 8'd21, y: 8'd3,  err: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd15, y: 8'd5,  err: 1'b0};
    vecs[2] = '{a: 8'd0,   b: 8'd15, y: 8'd0,  err: 1'b1};
    vecs[3] = '{a: 8'd17,  b: 8'd0,  y: 8'd0,  err: 1'b1};
    vecs[4] = '{a: 8'd48,  b: 8'd36, y: 8'd12, err: 1'b0};
    vecs[5] = '{a: 8'd255, b: 8'd17, y: 8'd17, err: 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Table: back-to-back requests, responses scored in order.
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].err, 1'b0);
    drain();
    tick();
    check("rsp_cnt after table", 32'(rsp_cnt), 6);
    check("idle req_ready", 32'(req_ready), 1);

    // Consumer stall for 5 cycles.
    rsp_ready = 1'b0;
    send(8'd12, 8'd18, 8'd6, 1'b0, 1'b0);
    wait_rsp_valid(n);
    for (int i = 0; i < 5; i++) begin
      check("stall rsp_valid", 32'(rsp_valid), 1);
      check("stall rsp_y", 32'(rsp_y), 6);
      check("stall req_ready", 32'(req_ready), 0);
      check("stall gcd_a hold", 32'(gcd_a), 12);
      check("stall rsp_cnt", 32'(rsp_cnt), 6);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("stall rsp_cnt after", 32'(rsp_cnt), 7);
    check("stall rsp_valid drop", 32'(rsp_valid), 0);
    check("stall queue empty", 32'(exp_q.size()), 0);

    // Done level already high entering WAIT: only the later rise counts.
    man_en = 1'b1; man_done = 1'b1; man_y = 8'd99; man_err = 1'b1;
    repeat (2) tick();
    send(8'd14, 8'd21, 8'd7, 1'b0, 1'b0);
    repeat (3) tick();
    man_done = 1'b0;
    repeat (3) tick();
    man_y = 8'd7; man_err = 1'b0; man_done = 1'b1;
    drain();
    repeat (8) tick();
    check("held-done rsp_cnt", 32'(rsp_cnt), 8);
    check("held-done no extra rsp", 32'(rsp_valid), 0);

`ifdef GCDM_TIMEOUT_EN
    // Timeout: core never completes.
    man_done = 1'b0; man_y = 8'd55; man_err = 1'b0;
    repeat (2) tick();
    send(8'd3, 8'd9, 8'd0, 1'b1, 1'b1);
    tick();
    wait_rsp_valid(n);
    check("timeout latency", 32'(n), 10);
    drain();
    // Done rises exactly on the terminal-count edge: done wins.
    send(8'd3, 8'd9, 8'd21, 1'b0, 1'b0);
    tick();
    repeat (9) tick();
    man_y = 8'd21; man_err = 1'b0; man_done = 1'b1;
    wait_rsp_valid(n);
    check("done-at-terminal latency", 32'(n), 1);
    drain();
    tick();
    check("rsp_cnt after timeout tests", 32'(rsp_cnt), 10);
    man_done = 1'b0;
`endif
    man_en = 1'b0;

    // Reset during WAIT abandons the request.
    send(8'd8, 8'd12, 8'd4, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    start_q.delete();
    check_reset_vals("mid-reset");
    repeat (12) tick();
    check("post-reset no rsp", 32'(rsp_valid), 0);
    check("post-reset rsp_cnt", 32'(rsp_cnt), 0);
    send(8'd8, 8'd12, 8'd4, 1'b0, 1'b0);
    drain();
    tick();
    check("rsp_cnt from reset", 32'(rsp_cnt), 1);
    check("final queue empty", 32'(start_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
